npu_input_formatter: RTL and testbench
======================================

// Module: npu_input_formatter
// PURPOSE
//  Parametrised next-generation NPU input path: buffers raw host words in a DEPTH-entry FIFO.
//  Converts each word to the PE datapath width on read, using a configurable fixed-point format
//  (shift, signedness, saturation).
//  Counts consumed inputs against a configured per-invocation total and pulses inputs_done.
//  Sits between the host input port and the scheduler; cfg ports are driven by npu_config_interface.
// PARAMETERS
//  IN_W    32  host input word width
//  DATA_W  16  converted output width (PE datapath); DATA_W <= IN_W
//  DEPTH   16  FIFO entries, power of two >= 2
//  CNT_W   16  width of the input-count register
// PORTS
//  CLK            in   1                 clock, all logic on rising edge
//  RST            in   1                 asynchronous, active-low reset
//  npu_rst        in   1                 synchronous soft reset (active-high): flush + clear cfg
//  in_wr_en       in   1                 host write strobe
//  in_data        in   IN_W              host write data
//  in_full        out  1                 FIFO full
//  in_empty       out  1                 FIFO empty
//  in_level       out  $clog2(DEPTH)+1   current occupancy
//  cfg_fmt_wr_en  in   1                 load format register from cfg_data[6:0]
//  cfg_cnt_wr_en  in   1                 load input-count register from cfg_data[CNT_W-1:0]
//  cfg_data       in   16                config word
//  rd_en          in   1                 scheduler read request
//  rd_data        out  DATA_W            converted word (registered)
//  rd_valid       out  1                 rd_data valid this cycle
//  inputs_done    out  1                 one-cycle pulse: last input of invocation delivered
//  overflow_err   out  1                 sticky: write attempted while full
//  underflow_err  out  1                 sticky: read attempted while empty
// BEHAVIOUR
//  - Reset (RST low, or npu_rst high at an edge): FIFO empty; in_full=0; in_empty=1; in_level=0.
//    Also rd_data=0, rd_valid=0, inputs_done=0, both err=0, fmt=0, cnt_cfg=0, consumed counter=0.
//  - Write accepted iff in_wr_en && !in_full; a simultaneous read does not free space that cycle.
//  - Read accepted iff rd_en && !in_empty; no write-to-read bypass.
//  - Read latency: accepted at edge t -> rd_data/rd_valid at t+1. rd_valid=0 in cycles without an accepted read.
//  - Write at edge t -> in_empty=0 after t; earliest rd_valid at t+2.
//  - in_full/in_empty/in_level are registered and exact; simultaneous accepted read+write leaves level unchanged.
//  - Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH; full/empty use an extra wrap bit.
//  - Format reg fmt[6:0]: [4:0]=shift (0..31), [5]=signed, [6]=saturate.
//  - Conversion applies at read time, using the fmt value in effect at the read edge:
//      x = signed ? (in >>> shift) : (in >> shift)   (IN_W wide)
//      saturate=1: clamp to [-2^(DATA_W-1), 2^(DATA_W-1)-1] if signed, [0, 2^DATA_W-1] if unsigned
//      saturate=0: rd_data = x[DATA_W-1:0] (truncate)
//  - A fmt write in the same cycle as a read: the read uses the OLD format.
//  - Count: the consumed counter increments per accepted read.
//    When it reaches cnt_cfg (cnt_cfg != 0), inputs_done pulses together with that rd_valid and the counter returns to 0.
//  - cnt_cfg = 0: unlimited; inputs_done never asserts.
//  - A cfg_cnt write clears the consumed counter.
//  - Errors are sticky until reset; a dropped write/read changes no other state.
// STRUCTURE
//  - npu_defines.vh (shared): FMT_SHIFT/FMT_SIGNED/FMT_SAT bit positions, CFG_W=16.
//  - Sub-module npu_sync_fifo #(W,DEPTH): storage, pointers, full/empty/level, overflow/underflow.
//  - The top holds the format register, the conversion/saturation datapath, the output register and the counter.
// TESTING
//  1. Reset: RST low mid-stream with 5 entries -> in_level=0, in_empty=1, rd_valid=0, errs=0.
//  2. Fill: 16 writes, then a 17th -> in_full=1, 17th dropped, overflow_err=1.
//     Then 16 reads return the data in order, in_empty=1.
//  3. Format: fmt=0x68 (signed, sat, shift 8), in=0x7FFF_0000 -> rd_data=0x7FFF.
//     in=0xFFFF_FF00 -> 0xFFFF. fmt=0x08, in=0x0012_3400 -> 0x1234.
//  4. Count: cnt=3, 7 reads -> inputs_done on reads 3 and 6 only, aligned with rd_valid.
//     cnt=0 -> never.
//  5. Boundary: read while empty -> underflow_err=1, rd_valid=0.
//     Simultaneous read+write at level 4 -> level stays 4.
//     Write+read at full -> write dropped.
//  6. npu_rst pulse with 3 entries and fmt set -> flushed, fmt=0; next write/read passes unconverted low DATA_W bits.

Source files
------------

// File: rtl/npu_input_formatter_pkg.sv
// Shared definitions for the NPU input formatter: config word width and
// the layout of the fixed-point format register.
package npu_input_formatter_pkg;

    localparam int CFG_W       = 16;
    localparam int FMT_W       = 7;
    localparam int FMT_SHIFT_W = 5;
    localparam int FMT_SIGNED  = 5;
    localparam int FMT_SAT     = 6;

    // Packed so that bit positions line up with FMT_SAT / FMT_SIGNED / shift.
    typedef struct packed {
        logic                   sat;
        logic                   sgn;
        logic [FMT_SHIFT_W-1:0] shift;
    } fmt_t;

endpackage

// File: rtl/npu_input_formatter_fifo.sv
// Synchronous FIFO with wrap-bit pointers, exact occupancy and sticky
// overflow/underflow flags. A flush behaves like reset.
module npu_input_formatter_fifo #(
    parameter int W     = 32,
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       wr_en,
    input  logic [W-1:0]               wr_data,
    input  logic                       rd_en,
    output logic [W-1:0]               rd_data,
    output logic                       wr_ok,
    output logic                       rd_ok,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       overflow_err,
    output logic                       underflow_err
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;

    // Status is derived only from the pointer flops, so it is glitch-free and
    // reflects a simultaneous read only after the edge.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign level   = wr_ptr - rd_ptr;
    assign wr_ok   = wr_en && !full;
    assign rd_ok   = rd_en && !empty;
    assign rd_data = mem[rd_ptr[AW-1:0]];

    // Storage array; no reset needed, contents are qualified by the pointers.
    always_ff @(posedge clk) begin
        if (wr_ok && !flush) begin
            mem[wr_ptr[AW-1:0]] <= wr_data;
        end
    end

    // Pointer and sticky error bookkeeping; dropped accesses only set a flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            overflow_err  <= 1'b0;
            underflow_err <= 1'b0;
        end else if (flush) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            overflow_err  <= 1'b0;
            underflow_err <= 1'b0;
        end else begin
            if (wr_ok) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (rd_ok) rd_ptr <= rd_ptr + (AW+1)'(1);
            if (wr_en && full)  overflow_err  <= 1'b1;
            if (rd_en && empty) underflow_err <= 1'b1;
        end
    end

endmodule

// File: rtl/npu_input_formatter.sv
// NPU input path: buffers host words, converts them to the PE width with a
// programmable shift/sign/saturate format on read, and counts consumed inputs.
module npu_input_formatter
    import npu_input_formatter_pkg::*;
#(
    parameter int IN_W   = 32,
    parameter int DATA_W = 16,
    parameter int DEPTH  = 16,
    parameter int CNT_W  = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       npu_rst,
    input  logic                       in_wr_en,
    input  logic [IN_W-1:0]            in_data,
    output logic                       in_full,
    output logic                       in_empty,
    output logic [$clog2(DEPTH):0]     in_level,
    input  logic                       cfg_fmt_wr_en,
    input  logic                       cfg_cnt_wr_en,
    input  logic [CFG_W-1:0]           cfg_data,
    input  logic                       rd_en,
    output logic [DATA_W-1:0]          rd_data,
    output logic                       rd_valid,
    output logic                       inputs_done,
    output logic                       overflow_err,
    output logic                       underflow_err
);

    fmt_t             fmt;
    logic [CNT_W-1:0] cnt_cfg;
    logic [CNT_W-1:0] consumed;
    logic [CNT_W-1:0] consumed_next;
    logic [IN_W-1:0]  fifo_rd_data;
    logic             wr_ok;
    logic             rd_ok;

    npu_input_formatter_fifo #(
        .W     (IN_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk           (clk),
        .rst_n         (rst_n),
        .flush         (npu_rst),
        .wr_en         (in_wr_en),
        .wr_data       (in_data),
        .rd_en         (rd_en),
        .rd_data       (fifo_rd_data),
        .wr_ok         (wr_ok),
        .rd_ok         (rd_ok),
        .full          (in_full),
        .empty         (in_empty),
        .level         (in_level),
        .overflow_err  (overflow_err),
        .underflow_err (underflow_err)
    );

    // Shift, then either clamp or truncate to DATA_W. Range tests use shifts
    // rather than slices so DATA_W == IN_W stays legal.
    function automatic logic [DATA_W-1:0] convert(input logic [IN_W-1:0] word, input fmt_t f);
        logic [IN_W-1:0]   x;
        logic [IN_W-1:0]   upper;
        logic              fits;
        logic [DATA_W-1:0] res;
        if (f.sgn) begin
            x     = IN_W'($signed(word) >>> f.shift);
            upper = IN_W'($signed(x) >>> (DATA_W-1));
            fits  = (upper == '0) || (upper == '1);
        end else begin
            x     = word >> f.shift;
            upper = x >> DATA_W;
            fits  = (upper == '0);
        end
        res = x[DATA_W-1:0];
        if (f.sat && !fits) begin
            if (!f.sgn)          res = '1;
            else if (x[IN_W-1])  res = {1'b1, {(DATA_W-1){1'b0}}};
            else                 res = {1'b0, {(DATA_W-1){1'b1}}};
        end
        return res;
    endfunction

    assign consumed_next = consumed + CNT_W'(1);

    // Output register, format/count config and the per-invocation counter.
    // A count write in the same cycle as a read restarts counting, so that
    // read neither counts nor raises inputs_done.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fmt         <= '0;
            cnt_cfg     <= '0;
            consumed    <= '0;
            rd_data     <= '0;
            rd_valid    <= 1'b0;
            inputs_done <= 1'b0;
        end else if (npu_rst) begin
            fmt         <= '0;
            cnt_cfg     <= '0;
            consumed    <= '0;
            rd_data     <= '0;
            rd_valid    <= 1'b0;
            inputs_done <= 1'b0;
        end else begin
            rd_valid    <= rd_ok;
            inputs_done <= 1'b0;
            if (rd_ok) rd_data <= convert(fifo_rd_data, fmt);
            if (cfg_fmt_wr_en) fmt <= fmt_t'(cfg_data[FMT_W-1:0]);
            if (cfg_cnt_wr_en) begin
                cnt_cfg  <= cfg_data[CNT_W-1:0];
                consumed <= '0;
            end else if (rd_ok) begin
                if ((cnt_cfg != '0) && (consumed_next == cnt_cfg)) begin
                    inputs_done <= 1'b1;
                    consumed    <= '0;
                end else begin
                    consumed    <= consumed_next;
                end
            end
        end
    end

endmodule

// File: tb/tb_npu_input_formatter.sv
// Randomised and directed bench for npu_input_formatter against a queue-based
// behavioural model; every cycle's outputs are compared on the falling edge.
module tb_npu_input_formatter;

    localparam int IN_W   = 32;
    localparam int DATA_W = 16;
    localparam int DEPTH  = 16;
    localparam int CNT_W  = 16;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              npu_rst = 1'b0;
    logic              in_wr_en = 1'b0;
    logic [IN_W-1:0]   in_data = '0;
    logic              cfg_fmt_wr_en = 1'b0;
    logic              cfg_cnt_wr_en = 1'b0;
    logic [15:0]       cfg_data = '0;
    logic              rd_en = 1'b0;
    logic              in_full;
    logic              in_empty;
    logic [4:0]        in_level;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic              inputs_done;
    logic              overflow_err;
    logic              underflow_err;

    npu_input_formatter #(
        .IN_W(IN_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .npu_rst       (npu_rst),
        .in_wr_en      (in_wr_en),
        .in_data       (in_data),
        .in_full       (in_full),
        .in_empty      (in_empty),
        .in_level      (in_level),
        .cfg_fmt_wr_en (cfg_fmt_wr_en),
        .cfg_cnt_wr_en (cfg_cnt_wr_en),
        .cfg_data      (cfg_data),
        .rd_en         (rd_en),
        .rd_data       (rd_data),
        .rd_valid      (rd_valid),
        .inputs_done   (inputs_done),
        .overflow_err  (overflow_err),
        .underflow_err (underflow_err)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;
    bit check_en = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    function automatic logic [DATA_W-1:0] ref_conv(input logic [IN_W-1:0] w, input logic [6:0] f);
        int     sh;
        longint v;
        longint lo;
        longint hi;
        sh = int'(f[4:0]);
        if (f[5]) v = longint'($signed(w));
        else      v = longint'(w);
        v = v >>> sh;
        if (f[6]) begin
            lo = f[5] ? -(longint'(1) <<< (DATA_W-1)) : 64'sd0;
            hi = f[5] ? (longint'(1) <<< (DATA_W-1)) - 1 : (longint'(1) <<< DATA_W) - 1;
            if (v < lo) v = lo;
            if (v > hi) v = hi;
        end
        return v[DATA_W-1:0];
    endfunction

    logic [IN_W-1:0]   m_q[$];
    logic [6:0]        m_fmt = '0;
    int                m_cnt = 0;
    int                m_consumed = 0;
    logic [DATA_W-1:0] m_data = '0;
    bit                m_valid = 1'b0;
    bit                m_done = 1'b0;
    bit                m_ovf = 1'b0;
    bit                m_udf = 1'b0;
    bit                m_wok;
    bit                m_rok;
    logic [IN_W-1:0]   m_word;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n || npu_rst) begin
            m_q.delete();
            m_fmt = '0; m_cnt = 0; m_consumed = 0; m_data = '0;
            m_valid = 1'b0; m_done = 1'b0; m_ovf = 1'b0; m_udf = 1'b0;
        end else begin
            m_valid = 1'b0;
            m_done  = 1'b0;
            m_wok = in_wr_en && (m_q.size() < DEPTH);
            m_rok = rd_en && (m_q.size() > 0);
            if (in_wr_en && !m_wok) m_ovf = 1'b1;
            if (rd_en && !m_rok)    m_udf = 1'b1;
            if (m_rok) begin
                m_word  = m_q.pop_front();
                m_data  = ref_conv(m_word, m_fmt);
                m_valid = 1'b1;
                if (!cfg_cnt_wr_en) begin
                    m_consumed++;
                    if (m_cnt != 0 && m_consumed == m_cnt) begin
                        m_done = 1'b1;
                        m_consumed = 0;
                    end
                end
            end
            if (m_wok) m_q.push_back(in_data);
            if (cfg_fmt_wr_en) m_fmt = cfg_data[6:0];
            if (cfg_cnt_wr_en) begin
                m_cnt = int'(cfg_data);
                m_consumed = 0;
            end
        end
    end

    // ---------------- cycle compare ----------------
    always @(negedge clk) begin
        if (check_en) begin
            chk("rd_valid", rd_valid, m_valid);
            if (m_valid) chk("rd_data", rd_data, m_data);
            chk("inputs_done", inputs_done, m_done);
            chk("in_level", in_level, m_q.size());
            chk("in_full", in_full, m_q.size() == DEPTH);
            chk("in_empty", in_empty, m_q.size() == 0);
            chk("overflow_err", overflow_err, m_ovf);
            chk("underflow_err", underflow_err, m_udf);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic clear_in();
        in_wr_en = 1'b0; rd_en = 1'b0; cfg_fmt_wr_en = 1'b0; cfg_cnt_wr_en = 1'b0; npu_rst = 1'b0;
    endtask

    task automatic step(input bit wr, input logic [IN_W-1:0] d, input bit rd);
        in_wr_en = wr; in_data = d; rd_en = rd;
        @(negedge clk);
        clear_in();
    endtask

    task automatic cfg(input bit is_cnt, input logic [15:0] v);
        cfg_data = v;
        if (is_cnt) cfg_cnt_wr_en = 1'b1;
        else        cfg_fmt_wr_en = 1'b1;
        @(negedge clk);
        clear_in();
    endtask

    task automatic soft_reset();
        npu_rst = 1'b1;
        @(negedge clk);
        clear_in();
    endtask

    logic [6:0] done_mask;

    initial begin
        clear_in();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_en = 1'b1;

        chk("reset_level", in_level, 0);
        chk("reset_empty", in_empty, 1);
        chk("reset_rd_data", rd_data, 0);

        chk("model_sat_pos", ref_conv(32'h7FFF_0000, 7'h68), 16'h7FFF);
        chk("model_neg", ref_conv(32'hFFFF_FF00, 7'h68), 16'hFFFF);
        chk("model_shift", ref_conv(32'h0012_3400, 7'h08), 16'h1234);
        chk("model_usat", ref_conv(32'h0123_4500, 7'h48), 16'hFFFF);

        // async reset mid-stream
        for (int i = 0; i < 5; i++) step(1'b1, $urandom, 1'b0);
        chk("pre_reset_level", in_level, 5);
        #2 rst_n = 1'b0;
        @(negedge clk);
        chk("rst_level", in_level, 0);
        chk("rst_empty", in_empty, 1);
        chk("rst_valid", rd_valid, 0);
        chk("rst_errs", {overflow_err, underflow_err}, 0);
        #2 rst_n = 1'b1;
        @(negedge clk);

        // fill and overflow, then drain in order
        for (int i = 0; i < 16; i++) step(1'b1, 32'h0001_0100 + i, 1'b0);
        step(1'b1, 32'hDEAD_BEEF, 1'b0);
        chk("fill_full", in_full, 1);
        chk("fill_ovf", overflow_err, 1);
        chk("fill_level", in_level, 16);
        for (int i = 0; i < 16; i++) begin
            step(1'b0, '0, 1'b1);
            chk("drain_data", rd_data, 16'h0100 + i);
        end
        chk("drain_empty", in_empty, 1);
        soft_reset();

        // formats
        cfg(1'b0, 16'h0068);
        step(1'b1, 32'h7FFF_0000, 1'b0); step(1'b0, '0, 1'b1);
        chk("fmt_sat_pos", rd_data, 16'h7FFF);
        step(1'b1, 32'hFFFF_FF00, 1'b0); step(1'b0, '0, 1'b1);
        chk("fmt_neg", rd_data, 16'hFFFF);
        cfg(1'b0, 16'h0008);
        step(1'b1, 32'h0012_3400, 1'b0); step(1'b0, '0, 1'b1);
        chk("fmt_shift", rd_data, 16'h1234);
        step(1'b1, 32'h0056_7800, 1'b0);
        cfg_data = 16'h0000; cfg_fmt_wr_en = 1'b1;
        step(1'b0, '0, 1'b1);
        chk("fmt_old_on_write", rd_data, 16'h5678);

        // input counting
        cfg(1'b1, 16'd3);
        for (int i = 0; i < 7; i++) step(1'b1, $urandom, 1'b0);
        done_mask = '0;
        for (int i = 0; i < 7; i++) begin
            step(1'b0, '0, 1'b1);
            done_mask[i] = inputs_done;
        end
        chk("cnt3_done_mask", done_mask, 7'b0100100);
        cfg(1'b1, 16'd0);
        for (int i = 0; i < 7; i++) step(1'b1, $urandom, 1'b0);
        done_mask = '0;
        for (int i = 0; i < 7; i++) begin
            step(1'b0, '0, 1'b1);
            done_mask[i] = inputs_done;
        end
        chk("cnt0_done_mask", done_mask, 7'b0000000);

        // boundaries
        soft_reset();
        step(1'b0, '0, 1'b1);
        chk("udf_flag", underflow_err, 1);
        chk("udf_valid", rd_valid, 0);
        for (int i = 0; i < 4; i++) step(1'b1, $urandom, 1'b0);
        step(1'b1, 32'h1111_2222, 1'b1);
        chk("rw_level4", in_level, 4);
        for (int i = 0; i < 12; i++) step(1'b1, $urandom, 1'b0);
        chk("full_before_rw", in_full, 1);
        step(1'b1, 32'h3333_4444, 1'b1);
        chk("full_rw_level", in_level, 15);
        chk("full_rw_ovf", overflow_err, 1);

        // soft reset flushes data and format
        soft_reset();
        for (int i = 0; i < 3; i++) step(1'b1, $urandom, 1'b0);
        cfg(1'b0, 16'h0068);
        soft_reset();
        chk("npu_rst_level", in_level, 0);
        chk("npu_rst_empty", in_empty, 1);
        step(1'b1, 32'hABCD_8765, 1'b0);
        step(1'b0, '0, 1'b1);
        chk("npu_rst_fmt0", rd_data, 16'h8765);

        // random traffic
        for (int c = 0; c < 3000; c++) begin
            in_wr_en = ($urandom_range(0, 99) < 55);
            rd_en    = ($urandom_range(0, 99) < 55);
            case ($urandom_range(0, 3))
                0:       in_data = $urandom;
                1:       in_data = $urandom_range(0, 32'h0003_FFFF);
                2:       in_data = 32'hFFFF_FFFF - $urandom_range(0, 32'h0003_FFFF);
                default: in_data = {$urandom_range(0, 255), 24'h0} ^ $urandom_range(0, 65535);
            endcase
            cfg_data = 16'($urandom);
            if ($urandom_range(0, 99) < 3) cfg_fmt_wr_en = 1'b1;
            if ($urandom_range(0, 99) < 2) begin
                cfg_cnt_wr_en = 1'b1;
                cfg_data = 16'($urandom_range(0, 5));
                rd_en = 1'b0;
            end
            if ($urandom_range(0, 999) < 5) npu_rst = 1'b1;
            @(negedge clk);
            clear_in();
        end

        repeat (3) @(negedge clk);
        check_en = 1'b0;
        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
